pixel_packer_mono8: RTL and testbench
=====================================

# pixel_packer_mono8

Packs a stream of single 8-bit Mono8 pixels, one per handshake, into 256-bit words of 32 pixels for the CustomLogic output path toward the framegrabber memory/host interface. It is the inverse of the input-side per-pixel sequentializer and sits downstream of the hls4ml/processing chain. It runs under ap_start/ap_done control, one frame per start, and pads and flags the final word of each frame.

## Interface
- OUT_ROWS, 20: frame height in pixels.
- OUT_COLS, 20: frame width in pixels. OUT_ROWS*OUT_COLS need not be a multiple of 32.
- PAD_VALUE, 8'h00: byte used to fill unused lanes of the frame's final word.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ap_start  in  1  frame start request.
- ap_ready  out  1  high in IDLE; start is accepted when ap_start && ap_ready.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse at frame completion.
- s_axis_tvalid  in  1  pixel valid.
- s_axis_tready  out  1  pixel accept.
- s_axis_tdata  in  8  pixel.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  word accept.
- m_axis_tdata  out  256  packed word; pixel k of the word occupies bits [8k+7:8k], first-received pixel in byte 0.
- m_axis_tlast  out  1  high with the frame's final word.
- cnt_col  out  $clog2(OUT_COLS)  column of the next pixel to be accepted.
- cnt_row  out  $clog2(OUT_ROWS)  row of the next pixel to be accepted.

## Operation
- Storage is a 32-byte accumulator plus a 256-bit output holding register with a valid flag and a tlast flag.
- States:
  - IDLE: ap_idle=1, ap_ready=1. Start handshake -> RUN.
  - RUN: s_axis_tready = !acc_full. A pixel handshake writes byte cnt_in_word and advances cnt_in_word (0..31), cnt_frame, cnt_col, and cnt_row. cnt_col wraps at OUT_COLS-1 and increments cnt_row.
  - A word is complete on the handshake of either the pixel with cnt_in_word==31 or the frame's last pixel (cnt_frame==N-1, N=OUT_ROWS*OUT_COLS).
  - On completion, the word moves to the output register if the register is empty or is handshaking this cycle. Otherwise acc_full is set and held until the transfer happens.
  - Bytes not written in the final word equal PAD_VALUE. The accumulator is preloaded with PAD_VALUE in every lane at each word start.
  - Handshake of the frame's last pixel -> DRAIN.
  - DRAIN: s_axis_tready=0. Once the tlast word has handshaked on m_axis -> DONE.
  - DONE: ap_done=1 for one cycle, all counters zeroed -> IDLE.
- Reset values: state IDLE, all counters 0, accumulator PAD_VALUE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, ap_done=0, ap_idle=1, ap_ready=1.
- A reset during RUN or DRAIN discards any partial or pending word with no output. The next frame starts clean.
- m_axis_tdata and m_axis_tlast are held stable while m_axis_tvalid=1 && !m_axis_tready.

## Timing
- Latency: m_axis_tvalid rises the cycle after the completing pixel handshake, provided the output register is free.
- Throughput: with m_axis_tready held high, 1 pixel/cycle is sustained with no bubbles across word boundaries.
- Backpressure: up to 32 further pixels are accepted into the accumulator while a word stalls on m_axis. s_axis_tready falls the cycle after the next word completes.
- Counters and cnt_col/cnt_row update on the clock edge following the handshake.
- ap_done asserts the cycle after the tlast handshake. ap_ready returns the cycle after that.
- Pixels presented in IDLE or DONE are not accepted.

## Structure
- The shared package holds:
  - PIXELS_PER_WORD=32 and the word/pixel width constants, shared with the sequentializer.
  - The state enum {IDLE, RUN, DRAIN, DONE}.
- One natural sub-module, `word_accumulator`, holds the byte-lane write, PAD preload, and full flag. The FSM, counters, and output register stay in the top level.

## Test plan
- 4x16 frame (N=64), pixel value = index, both readies always high -> two words: word0 byte k = k, word1 byte k = 32+k. tlast on word1 only. s_axis_tready never drops in RUN. ap_done pulses once.
- 5x5 frame (N=25), PAD_VALUE=8'hAA -> one word: bytes 0..24 = 0..24, bytes 25..31 = 8'hAA, tlast=1.
- 4x16 frame with m_axis_tready=0 for 70 cycles after start -> 64 pixels accepted. s_axis_tready drops after pixel 63. Words emerge unchanged in order once ready rises.
- Reset asserted after 40 pixels of a 4x16 frame, then a fresh start -> no tlast word from the aborted frame. The new frame's word0 byte 0 = first new pixel. Counters restart at 0.
- Two back-to-back 5x5 frames with ap_start held high -> each frame yields exactly one tlast word. ap_done pulses twice. cnt_row/cnt_col reach 4/4 and then return to 0/0.

Source files
------------

// File: rtl/pixel_packer_mono8_pkg.sv
// Word geometry and FSM states for the Mono8 packer.
// The geometry constants are shared with the input-side per-pixel sequentializer.
package pixel_packer_mono8_pkg;

   localparam int PIXEL_W         = 8;
   localparam int PIXELS_PER_WORD = 32;
   localparam int WORD_W          = PIXEL_W * PIXELS_PER_WORD;
   localparam int LANE_W          = $clog2(PIXELS_PER_WORD);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   function automatic logic [WORD_W-1:0] fill_word(input logic [PIXEL_W-1:0] b);
      return {PIXELS_PER_WORD{b}};
   endfunction

endpackage

// File: rtl/pixel_packer_mono8_word_accumulator.sv
// Collects pixels into one 32-lane word; unused lanes hold PAD_VALUE.
// word_dat already contains the byte being written this cycle, so a completing word can leave with no extra cycle.
module pixel_packer_mono8_word_accumulator
   import pixel_packer_mono8_pkg::*;
#(
   parameter logic [PIXEL_W-1:0] PAD_VALUE = 8'h00
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [LANE_W-1:0]   wr_lane,
   input  logic [PIXEL_W-1:0]  wr_data,
   input  logic                word_end,
   input  logic                flush,
   output logic [WORD_W-1:0]   word_dat,
   output logic                full
);

   logic [WORD_W-1:0] acc_q;

   always_comb begin
      word_dat = acc_q;
      if (wr_en) begin
         word_dat[int'(wr_lane) * PIXEL_W +: PIXEL_W] = wr_data;
      end
   end

   // A flushed word restarts as all-PAD; a completed word that cannot leave is parked as full.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         acc_q <= fill_word(PAD_VALUE);
         full  <= 1'b0;
      end else if (wr_en) begin
         acc_q <= word_dat;
         full  <= word_end;
      end
   end

endmodule

// File: rtl/pixel_packer_mono8.sv
// Packs Mono8 pixels into 256-bit words, one frame per ap_start, padding and flagging the last word.
// Word valid the cycle after it completes; one parked word lets input run 32 pixels ahead of a stalled output.
module pixel_packer_mono8
   import pixel_packer_mono8_pkg::*;
#(
   parameter int                 OUT_ROWS  = 20,
   parameter int                 OUT_COLS  = 20,
   parameter logic [PIXEL_W-1:0] PAD_VALUE = 8'h00
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ap_start,
   output logic                          ap_ready,
   output logic                          ap_idle,
   output logic                          ap_done,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic [PIXEL_W-1:0]            s_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [WORD_W-1:0]             m_axis_tdata,
   output logic                          m_axis_tlast,
   output logic [$clog2(OUT_COLS)-1:0]   cnt_col,
   output logic [$clog2(OUT_ROWS)-1:0]   cnt_row
);

   localparam int N       = OUT_ROWS * OUT_COLS;
   localparam int FRAME_W = (N > 1) ? $clog2(N) : 1;
   localparam int COL_W   = $clog2(OUT_COLS);
   localparam int ROW_W   = $clog2(OUT_ROWS);

   localparam logic [FRAME_W-1:0] LAST_PIX  = FRAME_W'(N - 1);
   localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(OUT_COLS - 1);
   localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(OUT_ROWS - 1);
   localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(PIXELS_PER_WORD - 1);

   state_t              state;
   logic [LANE_W-1:0]   cnt_in_word;
   logic [FRAME_W-1:0]  cnt_frame;
   logic                acc_full;
   logic                acc_last;
   logic [WORD_W-1:0]   acc_word;
   logic                s_hs;
   logic                m_hs;
   logic                last_pix;
   logic                word_end;
   logic                out_free;
   logic                take;
   logic                take_last;

   assign ap_idle       = (state == IDLE);
   assign ap_ready      = (state == IDLE);
   assign ap_done       = (state == DONE);
   assign s_axis_tready = (state == RUN) && !acc_full;

   assign s_hs      = s_axis_tvalid && s_axis_tready;
   assign m_hs      = m_axis_tvalid && m_axis_tready;
   assign last_pix  = (cnt_frame == LAST_PIX);
   assign word_end  = s_hs && ((cnt_in_word == LAST_LANE) || last_pix);
   assign out_free  = !m_axis_tvalid || m_axis_tready;
   // The output register takes either the parked word or the one completing right now.
   assign take      = out_free && (acc_full || word_end);
   assign take_last = acc_full ? acc_last : last_pix;

   pixel_packer_mono8_word_accumulator #(
      .PAD_VALUE (PAD_VALUE)
   ) u_acc (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (s_hs),
      .wr_lane  (cnt_in_word),
      .wr_data  (s_axis_tdata),
      .word_end (word_end),
      .flush    (take),
      .word_dat (acc_word),
      .full     (acc_full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt_in_word   <= '0;
         cnt_frame     <= '0;
         cnt_col       <= '0;
         cnt_row       <= '0;
         acc_last      <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
      end else begin
         if (take) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= acc_word;
            m_axis_tlast  <= take_last;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end

         if (word_end && !take) begin
            acc_last <= last_pix;
         end

         if (s_hs) begin
            cnt_in_word <= word_end ? '0 : cnt_in_word + 1'b1;
            cnt_frame   <= last_pix ? '0 : cnt_frame + 1'b1;
            if (cnt_col == LAST_COL) begin
               cnt_col <= '0;
               cnt_row <= (cnt_row == LAST_ROW) ? '0 : cnt_row + 1'b1;
            end else begin
               cnt_col <= cnt_col + 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (ap_start) state <= RUN;
            end
            RUN: begin
               if (s_hs && last_pix) state <= DRAIN;
            end
            DRAIN: begin
               if (m_hs && m_axis_tlast) state <= DONE;
            end
            DONE: begin
               state       <= IDLE;
               cnt_in_word <= '0;
               cnt_frame   <= '0;
               cnt_col     <= '0;
               cnt_row     <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_packer_mono8.sv
// Drives a 4x16 (PAD 00) and a 5x5 (PAD AA) packer with directed frames.
// A frame-level model predicts every output word, the counters and ap_done on each cycle.
module tb_pixel_packer_mono8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         s_vld = 1'b0;
   logic [7:0]   s_dat = 8'h00;
   logic         m_rdy = 1'b1;
   logic         a_start = 1'b0, b_start = 1'b0;

   logic         a_ready, a_idle, a_done, a_s_rdy, a_m_vld, a_m_last;
   logic [255:0] a_m_dat;
   logic [3:0]   a_col;
   logic [1:0]   a_row;
   logic         b_ready, b_idle, b_done, b_s_rdy, b_m_vld, b_m_last;
   logic [255:0] b_m_dat;
   logic [2:0]   b_col;
   logic [2:0]   b_row;

   always #5 clk = ~clk;

   pixel_packer_mono8 #(.OUT_ROWS(4), .OUT_COLS(16), .PAD_VALUE(8'h00)) u_a (
      .clk(clk), .reset(reset), .ap_start(a_start), .ap_ready(a_ready), .ap_idle(a_idle),
      .ap_done(a_done), .s_axis_tvalid(s_vld), .s_axis_tready(a_s_rdy), .s_axis_tdata(s_dat),
      .m_axis_tvalid(a_m_vld), .m_axis_tready(m_rdy), .m_axis_tdata(a_m_dat),
      .m_axis_tlast(a_m_last), .cnt_col(a_col), .cnt_row(a_row));

   pixel_packer_mono8 #(.OUT_ROWS(5), .OUT_COLS(5), .PAD_VALUE(8'hAA)) u_b (
      .clk(clk), .reset(reset), .ap_start(b_start), .ap_ready(b_ready), .ap_idle(b_idle),
      .ap_done(b_done), .s_axis_tvalid(s_vld), .s_axis_tready(b_s_rdy), .s_axis_tdata(s_dat),
      .m_axis_tvalid(b_m_vld), .m_axis_tready(m_rdy), .m_axis_tdata(b_m_dat),
      .m_axis_tlast(b_m_last), .cnt_col(b_col), .cnt_row(b_row));

   int n_chk = 0, n_pass = 0;
   int cur = 0;

   int          frm_cnt[2], wfill[2], exp_wr[2], exp_rd[2], log_n[2], done_cnt[2], acc_tot[2];
   bit          done_exp[2], hold_vld[2], hold_last[2], seen44[2];
   bit          exp_last[2][16], log_last[2][32];
   logic [255:0] hold_dat[2];
   logic [255:0] exp_dat[2][16];
   logic [255:0] log_dat[2][32];
   logic [7:0]  wbuf[2][32];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      else n_pass++;
   endtask

   function automatic logic [255:0] ramp(input int first, input int cnt, input logic [7:0] pad);
      logic [255:0] r;
      r = {32{pad}};
      for (int k = 0; k < cnt; k++) r[8*k +: 8] = 8'(first + k);
      return r;
   endfunction

   task automatic model_step(input int id, input int n, input int cols, input logic [7:0] pad,
                             input logic rst, input logic sv, input logic sr, input logic [7:0] sd,
                             input logic mv, input logic mr, input logic ml, input logic [255:0] md,
                             input logic dn, input int col, input int row);
      logic [255:0] w;
      chk("cnt_col", 256'(col), 256'(frm_cnt[id] % cols));
      chk("cnt_row", 256'(row), 256'(frm_cnt[id] / cols));
      chk("ap_done", 256'(dn), 256'(done_exp[id]));
      if (hold_vld[id]) begin
         chk("hold_tvalid", 256'(mv), 256'(1));
         chk("hold_tdata", md, hold_dat[id]);
         chk("hold_tlast", 256'(ml), 256'(hold_last[id]));
      end
      if (dn) done_cnt[id]++;
      if (col == 4 && row == 4) seen44[id] = 1'b1;
      if (rst) begin
         frm_cnt[id] = 0; wfill[id] = 0; exp_rd[id] = exp_wr[id];
         hold_vld[id] = 1'b0; done_exp[id] = 1'b0;
         return;
      end
      done_exp[id] = mv && mr && ml;
      if (mv && mr) begin
         chk("word_expected", 256'(exp_rd[id] != exp_wr[id]), 256'(1));
         if (exp_rd[id] != exp_wr[id]) begin
            chk("word_tdata", md, exp_dat[id][exp_rd[id] % 16]);
            chk("word_tlast", 256'(ml), 256'(exp_last[id][exp_rd[id] % 16]));
            exp_rd[id]++;
         end
         log_dat[id][log_n[id] % 32]  = md;
         log_last[id][log_n[id] % 32] = ml;
         log_n[id]++;
      end
      hold_vld[id]  = mv && !mr;
      hold_dat[id]  = md;
      hold_last[id] = ml;
      if (sv && sr) begin
         wbuf[id][wfill[id]] = sd;
         wfill[id]++; frm_cnt[id]++; acc_tot[id]++;
         if (wfill[id] == 32 || frm_cnt[id] == n) begin
            w = {32{pad}};
            for (int k = 0; k < wfill[id]; k++) w[8*k +: 8] = wbuf[id][k];
            exp_dat[id][exp_wr[id] % 16]  = w;
            exp_last[id][exp_wr[id] % 16] = (frm_cnt[id] == n);
            exp_wr[id]++;
            wfill[id] = 0;
            if (frm_cnt[id] == n) frm_cnt[id] = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      model_step(0, 64, 16, 8'h00, reset, s_vld, a_s_rdy, s_dat, a_m_vld, m_rdy, a_m_last,
                 a_m_dat, a_done, int'(a_col), int'(a_row));
      model_step(1, 25, 5, 8'hAA, reset, s_vld, b_s_rdy, s_dat, b_m_vld, m_rdy, b_m_last,
                 b_m_dat, b_done, int'(b_col), int'(b_row));
   end

   task automatic start(input int id);
      if (id == 0) a_start = 1'b1; else b_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0; b_start = 1'b0;
   endtask

   task automatic send(input int npix, input int base, output int cycles);
      int i; logic hs;
      i = 0; cycles = 0;
      s_vld = 1'b1; s_dat = 8'(base);
      while (i < npix && cycles < 2000) begin
         @(negedge clk);
         hs = s_vld && ((cur == 1) ? b_s_rdy : a_s_rdy);
         @(posedge clk); #1;
         cycles++;
         if (hs) begin i++; s_dat = 8'(base + i); end
      end
      s_vld = 1'b0;
      chk("send_complete", 256'(i), 256'(npix));
   endtask

   task automatic wait_done(input int id, input int target);
      int g;
      g = 0;
      while (done_cnt[id] < target && g < 500) begin @(posedge clk); #1; g++; end
      chk("done_seen", 256'(done_cnt[id] >= target), 256'(1));
   endtask

   initial begin
      int cyc, d0, l0, t0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // reset state
      chk("rst_idle", 256'(a_idle), 256'(1));
      chk("rst_ready", 256'(a_ready), 256'(1));
      chk("rst_tready", 256'(a_s_rdy), 256'(0));
      chk("rst_tvalid", 256'(a_m_vld), 256'(0));
      chk("rst_tlast", 256'(a_m_last), 256'(0));
      chk("rst_tdata", a_m_dat, 256'(0));
      chk("rst_done", 256'(a_done), 256'(0));
      chk("rst_b_tdata", b_m_dat, 256'(0));
      chk("rst_b_idle", 256'(b_idle && b_ready), 256'(1));

      // pixels offered while idle are refused
      cur = 0; m_rdy = 1'b1;
      s_vld = 1'b1; s_dat = 8'h55;
      repeat (4) @(posedge clk); #1;
      chk("idle_tready", 256'(a_s_rdy), 256'(0));
      s_vld = 1'b0;
      chk("idle_no_accept", 256'(acc_tot[0]), 256'(0));

      // 4x16 frame, readies always high
      d0 = done_cnt[0]; l0 = log_n[0];
      start(0);
      send(64, 0, cyc);
      chk("t1_no_bubble", 256'(cyc), 256'(64));
      wait_done(0, d0 + 1);
      repeat (3) @(posedge clk); #1;
      chk("t1_done_once", 256'(done_cnt[0] - d0), 256'(1));
      chk("t1_word_count", 256'(log_n[0] - l0), 256'(2));
      chk("t1_word0", log_dat[0][l0 % 32], ramp(0, 32, 8'h00));
      chk("t1_word0_last", 256'(log_last[0][l0 % 32]), 256'(0));
      chk("t1_word1", log_dat[0][(l0 + 1) % 32], ramp(32, 32, 8'h00));
      chk("t1_word1_byte31", 256'(log_dat[0][(l0 + 1) % 32][255:248]), 256'(8'h3F));
      chk("t1_word1_last", 256'(log_last[0][(l0 + 1) % 32]), 256'(1));
      chk("t1_ready_back", 256'(a_ready), 256'(1));

      // 5x5 frame with PAD 0xAA
      cur = 1; d0 = done_cnt[1]; l0 = log_n[1];
      start(1);
      send(25, 0, cyc);
      wait_done(1, d0 + 1);
      repeat (2) @(posedge clk); #1;
      chk("t2_word_count", 256'(log_n[1] - l0), 256'(1));
      chk("t2_word", log_dat[1][l0 % 32], ramp(0, 25, 8'hAA));
      chk("t2_byte24", 256'(log_dat[1][l0 % 32][199:192]), 256'(8'h18));
      chk("t2_byte25_pad", 256'(log_dat[1][l0 % 32][207:200]), 256'(8'hAA));
      chk("t2_last", 256'(log_last[1][l0 % 32]), 256'(1));

      // 4x16 frame with output stalled for 70 cycles
      cur = 0; m_rdy = 1'b0;
      d0 = done_cnt[0]; l0 = log_n[0]; t0 = acc_tot[0];
      start(0);
      fork
         send(64, 0, cyc);
         begin
            repeat (69) @(posedge clk); #1;
            chk("t3_accepted", 256'(acc_tot[0] - t0), 256'(64));
            chk("t3_tready_low", 256'(a_s_rdy), 256'(0));
            chk("t3_tvalid_held", 256'(a_m_vld), 256'(1));
            chk("t3_held_byte0", 256'(a_m_dat[7:0]), 256'(8'h00));
            chk("t3_nothing_out", 256'(log_n[0] - l0), 256'(0));
            @(posedge clk); #1;
            m_rdy = 1'b1;
         end
      join
      wait_done(0, d0 + 1);
      chk("t3_word_count", 256'(log_n[0] - l0), 256'(2));
      chk("t3_word0", log_dat[0][l0 % 32], ramp(0, 32, 8'h00));
      chk("t3_word1", log_dat[0][(l0 + 1) % 32], ramp(32, 32, 8'h00));
      chk("t3_word1_last", 256'(log_last[0][(l0 + 1) % 32]), 256'(1));

      // reset in the middle of a frame, then a clean frame
      d0 = done_cnt[0];
      start(0);
      send(40, 0, cyc);
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("t4_col_zero", 256'(a_col), 256'(0));
      chk("t4_row_zero", 256'(a_row), 256'(0));
      chk("t4_tvalid_zero", 256'(a_m_vld), 256'(0));
      chk("t4_idle", 256'(a_idle), 256'(1));
      l0 = log_n[0];
      start(0);
      send(64, 100, cyc);
      wait_done(0, d0 + 1);
      repeat (2) @(posedge clk); #1;
      chk("t4_one_done", 256'(done_cnt[0] - d0), 256'(1));
      chk("t4_word_count", 256'(log_n[0] - l0), 256'(2));
      chk("t4_byte0", 256'(log_dat[0][l0 % 32][7:0]), 256'(8'd100));
      chk("t4_word0_last", 256'(log_last[0][l0 % 32]), 256'(0));
      chk("t4_word1", log_dat[0][(l0 + 1) % 32], ramp(132, 32, 8'h00));

      // two back-to-back 5x5 frames with ap_start held
      cur = 1; d0 = done_cnt[1]; l0 = log_n[1]; seen44[1] = 1'b0;
      b_start = 1'b1;
      send(50, 0, cyc);
      b_start = 1'b0;
      wait_done(1, d0 + 2);
      repeat (3) @(posedge clk); #1;
      chk("t5_two_dones", 256'(done_cnt[1] - d0), 256'(2));
      chk("t5_word_count", 256'(log_n[1] - l0), 256'(2));
      chk("t5_f0", log_dat[1][l0 % 32], ramp(0, 25, 8'hAA));
      chk("t5_f1", log_dat[1][(l0 + 1) % 32], ramp(25, 25, 8'hAA));
      chk("t5_lasts", 256'({log_last[1][l0 % 32], log_last[1][(l0 + 1) % 32]}), 256'(2'b11));
      chk("t5_reached_4_4", 256'(seen44[1]), 256'(1));
      chk("t5_col_back", 256'(b_col), 256'(0));
      chk("t5_row_back", 256'(b_row), 256'(0));
      chk("t5_idle", 256'(b_idle), 256'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
